circle_point_gen: RTL and testbench

- Inverse of the point-in-circle test: given a circle centre on the 16x16 laser grid, enumerates every grid point covered by the circle, one per output handshake, in raster order.
- Feeds coverage-map builders and golden-model checkers in the laser-placement datapath.
- Uses the same coverage rule as the inside test: offset (dx,dy) is covered iff dx*dx + dy*dy <= R*R. For R=4 this is equivalent to |dx|+|dy|<=4, plus offsets (2,3) and (3,2).

---
 rtl/circle_point_gen.sv | 163 ++++++++++++++++
 tb/tb_circle_point_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/circle_point_gen.sv
// ============================================================================
// circle_point_gen : raster-order enumerator of grid points covered by a circle
// Rev 1.0
// ============================================================================
`default_nettype none

module circle_point_gen #(
  parameter int GRID_W = 4,
  parameter int R      = 4,
  parameter int CNT_W  = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [GRID_W-1:0] cx,
  input  logic [GRID_W-1:0] cy,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GRID_W-1:0] out_x,
  output logic [GRID_W-1:0] out_y,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam int OW = GRID_W + 2;
  localparam int SW = 2 * OW;

  localparam logic signed [OW-1:0] c_dmin = OW'(-R);
  localparam logic signed [OW-1:0] c_dmax = OW'(R);
  localparam logic signed [OW-1:0] c_gmax = OW'((1 << GRID_W) - 1);
  localparam logic        [SW-1:0] c_r2   = SW'(R * R);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [OW-1:0]     dx_q, dx_d;
  logic signed [OW-1:0]     dy_q, dy_d;
  logic        [GRID_W-1:0] cx_q, cx_d;
  logic        [GRID_W-1:0] cy_q, cy_d;
  logic        [CNT_W-1:0]  count_q, count_d;
  logic                     out_valid_q;
  logic        [GRID_W-1:0] out_x_q;
  logic        [GRID_W-1:0] out_y_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     w_nvalid;
  logic        [GRID_W-1:0] w_nx;
  logic        [GRID_W-1:0] w_ny;

  // Point is emitted only if it lands on the grid and lies inside the circle.
  function automatic logic cand_ok(
    input logic        [GRID_W-1:0] c_x,
    input logic        [GRID_W-1:0] c_y,
    input logic signed [OW-1:0]     ox,
    input logic signed [OW-1:0]     oy
  );
    logic signed [OW-1:0] px;
    logic signed [OW-1:0] py;
    logic signed [SW-1:0] ex;
    logic signed [SW-1:0] ey;
    logic        [SW-1:0] d2;
    px = $signed({2'b00, c_x}) + ox;
    py = $signed({2'b00, c_y}) + oy;
    ex = SW'(ox);
    ey = SW'(oy);
    d2 = $unsigned(ex * ex + ey * ey);
    return !px[OW-1] && (px <= c_gmax) && !py[OW-1] && (py <= c_gmax) && (d2 <= c_r2);
  endfunction

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          dx_d    = c_dmin;
          dy_d    = c_dmin;
          count_d = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Advance on a skipped candidate or a completed handshake; otherwise hold.
        if (!out_valid_q || out_ready) begin
          if (out_valid_q) begin
            count_d = count_q + CNT_W'(1);
          end
          if (dx_q == c_dmax) begin
            dx_d = c_dmin;
            if (dy_q == c_dmax) begin
              state_d = S_DONE;
            end else begin
              dy_d = dy_q + OW'(1);
            end
          end else begin
            dx_d = dx_q + OW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next candidate so they never depend on inputs combinationally.
  assign w_nvalid = (state_d == S_SCAN) && cand_ok(cx_d, cy_d, dx_d, dy_d);
  assign w_nx     = cx_d + dx_d[GRID_W-1:0];
  assign w_ny     = cy_d + dy_d[GRID_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      dx_q        <= '0;
      dy_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      count_q     <= count_d;
      out_valid_q <= w_nvalid;
      out_x_q     <= w_nvalid ? w_nx : '0;
      out_y_q     <= w_nvalid ? w_ny : '0;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign done      = done_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_circle_point_gen.sv
// ============================================================================
// tb_circle_point_gen : table-driven and randomized bench for circle_point_gen
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_circle_point_gen;

  localparam int GRID_W = 4;
  localparam int R      = 4;
  localparam int CNT_W  = 7;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [GRID_W-1:0] cx;
  logic [GRID_W-1:0] cy;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [GRID_W-1:0] out_x;
  logic [GRID_W-1:0] out_y;
  logic              done;
  logic [CNT_W-1:0]  count;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int got_q[$];

  typedef struct {
    logic [GRID_W-1:0] cx;
    logic [GRID_W-1:0] cy;
    int                rdy_pct;
    bit                poke;
    int                exp_n;
    int                first_xy;
    int                last_xy;
  } vec_t;

  vec_t tbl[9];
  vec_t v_rst;

  circle_point_gen #(
    .GRID_W (GRID_W),
    .R      (R),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .done      (done),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: every on-grid offset inside the circle, raster order, encoded x*16+y.
  function automatic void build_model(input int x, input int y);
    int px;
    int py;
    exp_q.delete();
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        px = x + dx;
        py = y + dy;
        if (px >= 0 && px < (1 << GRID_W) && py >= 0 && py < (1 << GRID_W) &&
            dx * dx + dy * dy <= R * R)
          exp_q.push_back(px * 16 + py);
      end
    end
  endfunction

  task automatic run_scan(input vec_t v);
    int          cyc;
    int          done_cyc;
    bit          hold;
    logic [3:0]  hx;
    logic [3:0]  hy;
    int          n;
    build_model(int'(v.cx), int'(v.cy));
    got_q.delete();
    @(negedge CLK);
    start = 1'b1; cx = v.cx; cy = v.cy; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    cx = 4'($urandom_range(15));
    cy = 4'($urandom_range(15));
    cyc = 1; done_cyc = 0; hold = 1'b0; hx = '0; hy = '0;
    while (cyc < 1000 && done_cyc == 0) begin
      if (hold)
        chk("hold_stable", 32'({out_valid, out_x, out_y}), 32'({1'b1, hx, hy}));
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (v.poke && cyc == 20) begin
          start = 1'b1; cx = 4'd3; cy = 4'd3;
        end else begin
          start = 1'b0;
        end
        out_ready = ($urandom_range(99) < v.rdy_pct);
        if (out_valid && out_ready) got_q.push_back(int'(out_x) * 16 + int'(out_y));
        hold = out_valid && !out_ready;
        hx = out_x; hy = out_y;
        @(negedge CLK);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc != 0), 32'd1);
    if (v.rdy_pct == 100) chk("done_cycle", 32'(done_cyc), 32'd82);
    chk("count_at_done", 32'(count), 32'(exp_q.size()));
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("valid_at_done", 32'(out_valid), 32'd0);
    chk("n_points", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("point_xy16", 32'(got_q[i]), 32'(exp_q[i]));
    if (v.exp_n >= 0) begin
      chk("n_points_table", 32'(got_q.size()), 32'(v.exp_n));
      if (got_q.size() > 0) begin
        chk("first_xy16", 32'(got_q[0]), 32'(v.first_xy));
        chk("last_xy16", 32'(got_q[got_q.size()-1]), 32'(v.last_xy));
      end
    end
    @(negedge CLK);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("count_hold", 32'(count), 32'(exp_q.size()));
  endtask

  initial begin
    int hs;
    int cyc;
    RST = 1'b1; start = 1'b0; cx = '0; cy = '0; out_ready = 1'b0;

    //           cx     cy     rdy  poke  n   first        last
    tbl[0] = '{4'd8,  4'd8,  100, 1'b0, 49, 8*16+4,   8*16+12};
    tbl[1] = '{4'd0,  4'd0,  100, 1'b0, 17, 0,        0*16+4};
    tbl[2] = '{4'd15, 4'd15, 100, 1'b0, 17, 15*16+11, 15*16+15};
    tbl[3] = '{4'd8,  4'd8,  50,  1'b0, 49, 8*16+4,   8*16+12};
    tbl[4] = '{4'd8,  4'd8,  100, 1'b1, 49, 8*16+4,   8*16+12};
    for (int i = 5; i < 9; i++)
      tbl[i] = '{4'($urandom_range(15)), 4'($urandom_range(15)), 70, 1'b0, -1, 0, 0};
    v_rst = '{4'd8, 4'd8, 100, 1'b0, 49, 8*16+4, 8*16+12};

    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) run_scan(tbl[i]);

    // Reset in the middle of a scan, after the 10th accepted point.
    @(negedge CLK);
    start = 1'b1; cx = 4'd8; cy = 4'd8; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 10 && cyc < 200) begin
      if (out_valid && out_ready) hs++;
      @(negedge CLK);
      cyc++;
    end
    chk("hs_before_rst", 32'(hs), 32'd10);
    chk("count_before_rst", 32'(count), 32'd10);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("postrst_done", 32'(done), 32'd0);
    run_scan(v_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
